// File: rtl/lbll_adder.sv
`default_nettype none
//============================================================================
// Module      : lbll_adder
// Description : Registered, key-locked WIDTH-bit adder. The output register
//               captures (a_in + b_in) mod 2^WIDTH when the key matches
//               CORRECT_KEY. Any other key XORs a non-zero, key-dependent
//               mask into the sum ahead of the register.
//
// Ports       : clk    - clock, all state on the rising edge
//               rst_n  - asynchronous active-low reset (clears y_out)
//               a_in   - operand A, unsigned, WIDTH bits
//               b_in   - operand B, unsigned, WIDTH bits
//               key    - locking key, KEY_BITS bits, static in operation
//               y_out  - registered (corrupted-if-locked) sum, WIDTH bits
//
// Revision    : 1.0 - initial release
//============================================================================
module lbll_adder #(
    parameter int                    WIDTH       = 6,
    parameter int                    KEY_BITS    = 8,
    parameter logic [KEY_BITS-1:0]   CORRECT_KEY = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [KEY_BITS-1:0]  key,
    output logic [WIDTH-1:0]     y_out
);

    localparam logic [WIDTH-1:0] c_BIT0 = WIDTH'(1);

    logic [WIDTH-1:0]    w_sum;
    logic [WIDTH-1:0]    w_carry;
    logic [KEY_BITS-1:0] w_m;
    logic                w_locked;
    logic [WIDTH-1:0]    w_fold;
    logic [WIDTH-1:0]    w_mask;
    logic [WIDTH-1:0]    w_next_y;
    logic [WIDTH-1:0]    r_y;

    //------------------------------------------------------------------------
    // Ripple-carry chain of full adders. Carry-in is zero; the carry out of
    // the top bit is never built, so the sum wraps mod 2^WIDTH.
    //------------------------------------------------------------------------
    assign w_carry[0] = 1'b0;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            assign w_sum[i] = a_in[i] ^ b_in[i] ^ w_carry[i];
            if (i < WIDTH - 1) begin : g_carry
                assign w_carry[i+1] = (a_in[i] & b_in[i]) |
                                      (w_carry[i] & (a_in[i] ^ b_in[i]));
            end
        end
    endgenerate

    //------------------------------------------------------------------------
    // Lock mask. Key bits are folded onto the result width by XOR-ing all
    // key-difference bits that share the same index modulo WIDTH. The fold
    // alone can be zero for a wrong key (e.g. differences that cancel), so
    // bit 0 is forced whenever the key is wrong to guarantee corruption.
    //------------------------------------------------------------------------
    assign w_m      = key ^ CORRECT_KEY;
    assign w_locked = |w_m;

    always_comb begin
        w_fold = '0;
        for (int j = 0; j < KEY_BITS; j++) begin
            w_fold[j % WIDTH] = w_fold[j % WIDTH] ^ w_m[j];
        end
    end

    assign w_mask   = w_locked ? (w_fold | c_BIT0) : '0;
    assign w_next_y = w_sum ^ w_mask;

    //------------------------------------------------------------------------
    // Output register: sole state element, cleared asynchronously.
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_next_y;
        end
    end

    assign y_out = r_y;

endmodule
`default_nettype wire

// File: tb/tb_lbll_adder.sv
`default_nettype none
//============================================================================
// Module      : tb_lbll_adder
// Description : Directed self-checking bench for lbll_adder with
//               WIDTH=6, KEY_BITS=8, CORRECT_KEY=8'hA5.
//
// Ports       : none
//
// Revision    : 1.0 - initial release
//============================================================================
module tb_lbll_adder;

    logic       clk;
    logic       rst_n;
    logic [5:0] a_in;
    logic [5:0] b_in;
    logic [7:0] key;
    logic [5:0] y_out;

    int checks;
    int errors;

    lbll_adder #(
        .WIDTH       (6),
        .KEY_BITS    (8),
        .CORRECT_KEY (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_in  (a_in),
        .b_in  (b_in),
        .key   (key),
        .y_out (y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs,
                         input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive operands on the falling edge, then check just after the
    // following rising edge.
    task automatic step(input string tag, input logic [5:0] a,
                        input logic [5:0] b, input logic [7:0] k,
                        input logic [5:0] exp);
        @(negedge clk);
        a_in = a;
        b_in = b;
        key  = k;
        @(posedge clk);
        #1;
        check(tag, y_out, exp);
    endtask

    initial begin
        logic [5:0] ra;
        logic [5:0] rb;
        logic [5:0] rexp;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        key    = 8'hA5;

        // Reset state, held across edges
        #12;
        check("reset_state", y_out, 6'd0);
        @(posedge clk);
        #1;
        check("reset_hold", y_out, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sum with correct key, then register holds while inputs move
        step("sum_5_9", 6'd5, 6'd9, 8'hA5, 6'd14);
        #1;
        a_in = 6'd1;
        b_in = 6'd1;
        #5;
        check("hold_until_edge", y_out, 6'd14);

        // Async reset mid-cycle while y_out=14
        rst_n = 1'b0;
        #1;
        check("async_reset_now", y_out, 6'd0);
        @(posedge clk);
        #1;
        check("reset_low_edge1", y_out, 6'd0);
        @(posedge clk);
        #1;
        check("reset_low_edge2", y_out, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap-around with correct key
        step("wrap_63_1",  6'd63, 6'd1,  8'hA5, 6'd0);
        step("wrap_63_63", 6'd63, 6'd63, 8'hA5, 6'd62);
        step("zero_0_0",   6'd0,  6'd0,  8'hA5, 6'd0);
        step("wrap_32_32", 6'd32, 6'd32, 8'hA5, 6'd0);

        // Wrong keys, a=5, b=9 (sum 001110)
        // A4: m=01, mask=000001 -> 001111
        step("key_A4", 6'd5, 6'd9, 8'hA4, 6'd15);
        // 65: m=C0, bits 6,7 fold onto 0,1 -> mask=000011 -> 001101
        step("key_65", 6'd5, 6'd9, 8'h65, 6'd13);
        // 5A: m=FF, bits 0/6 and 1/7 cancel, bits 2..5 stay set ->
        // fold=111100, mask=111101 -> 001110 ^ 111101 = 110011
        step("key_5A", 6'd5, 6'd9, 8'h5A, 6'd51);
        // Key restored takes effect on the next edge
        step("key_restore", 6'd5, 6'd9, 8'hA5, 6'd14);

        // Random operands, changed 6ns after a rising edge
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #6;
            ra   = 6'($urandom_range(0, 63));
            rb   = 6'($urandom_range(0, 63));
            rexp = 6'((int'(ra) + int'(rb)) % 64);
            a_in = ra;
            b_in = rb;
            key  = 8'hA5;
            @(posedge clk);
            #1;
            check("random_sum", y_out, rexp);
        end

        // Reset mid-operation, then release with new operands
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset", y_out, 6'd0);
        a_in = 6'd10;
        b_in = 6'd20;
        key  = 8'hA5;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_release", y_out, 6'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
